// File: rtl/fifo_rd_stage.sv
// FIFO read stage: burst reads into a 2-entry skid buffer with valid/ready out.
// Optional RD_STAGE_PARITY_EN adds m_parity (XOR of m_data).
module fifo_rd_stage #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef RD_STAGE_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  logic [FIFO_WIDTH-1:0] data0_q, data0_d;
  logic [FIFO_WIDTH-1:0] data1_q, data1_d;
  logic                  last0_q, last0_d;
  logic                  last1_q, last1_d;

  logic pop;
  logic room;
  logic at_max;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = data0_q;
  assign m_last  = m_valid & last0_q;
  assign pop     = m_valid & m_ready;
  assign at_max  = (rd_cnt_q == CNT_MAX);

  // Buffered plus in-flight words, less this cycle's pop, must stay below 2.
  assign room = ({1'b0, occ_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});

`ifdef RD_STAGE_PARITY_EN
  assign m_parity = ^m_data;
`endif

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    fifo_rd_en = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (!fifo_empty) state_d = BURST;
      end
      (state_q == BURST): begin
        fifo_rd_en = !fifo_empty && room;
        if (fifo_rd_en) begin
          if (at_max) begin
            rd_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      (state_q == DRAIN): begin
        if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    infl_d      = fifo_rd_en;
    infl_last_d = fifo_rd_en && at_max;
    occ_d       = occ_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    case ({infl_q, pop})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = fifo_data_out;
          last0_d = infl_last_q;
        end else begin
          data1_d = fifo_data_out;
          last1_d = infl_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = fifo_data_out;
          last0_d = infl_last_q;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = fifo_data_out;
          last1_d = infl_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      occ_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: FIFO model, scoreboard on word order/last tags,
// plus directed literal checks for bursts, stalls, gaps and reset.
module tb_fifo_rd_stage;
  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
`ifdef RD_STAGE_PARITY_EN
  logic         m_parity;
`endif

  fifo_rd_stage #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
`ifdef RD_STAGE_PARITY_EN
    , .m_parity(m_parity)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:1023];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && rd_ptr < wr_ptr) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [W-1:0] exp_q[$];
  int           out_idx = 0;
  int           n_rd = 0;
  int           n_xfer = 0;
  int           cyc = 0;
  logic [W-1:0] log_d[$];
  bit           log_l[$];
  int           log_c[$];
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      n_rd = 0;
      n_xfer = 0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_while_empty", {31'd0, fifo_empty}, 0);
        n_rd++;
      end
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 1);
        check("stall_data", {16'd0, m_data}, {16'd0, prev_data});
        check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          check("sb_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
          check("sb_last", {31'd0, m_last},
                {31'd0, (out_idx % BL) == BL - 1});
        end
        out_idx++;
        n_xfer++;
        log_d.push_back(m_data);
        log_l.push_back(m_last);
        log_c.push_back(cyc);
      end
      check("occupancy", {31'd0, (n_rd - n_xfer) <= 2}, 1);
`ifdef RD_STAGE_PARITY_EN
      if (m_valid) check("parity_rule", {31'd0, m_parity}, {31'd0, ^m_data});
`endif
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < bound) begin
      tick(1);
      k++;
    end
    check("drain_timeout", {31'd0, k < bound}, 1);
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endtask

  initial begin
    int k;
    int n0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    tick(2);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    check("rst_valid", {31'd0, m_valid}, 0);
    check("rst_data", {16'd0, m_data}, 0);
    check("rst_last", {31'd0, m_last}, 0);

    // Preloaded 8 words, ready held high
    rst_n = 1'b1;
    m_ready = 1'b1;
    #2;
    check("no_read_edge1", {31'd0, fifo_rd_en}, 0);
    tick(1);
    check("read_after_edge1", {31'd0, fifo_rd_en}, 1);
    drain(100);
    check("b8_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("b8_data", {16'd0, log_d[i]}, i + 1);
        check("b8_last", {31'd0, log_l[i]}, {31'd0, i == 3 || i == 7});
      end
      for (int i = 0; i < 3; i++) begin
        check("b8_rate_a", log_c[i+1] - log_c[i], 1);
        check("b8_rate_b", log_c[i+5] - log_c[i+4], 1);
      end
    end

    // Two words, then two more five cycles later
    clear_log();
    push(16'h0011);
    push(16'h0012);
    tick(5);
    push(16'h0013);
    push(16'h0014);
    drain(100);
    check("gap_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      check("gap_last1", {31'd0, log_l[1]}, 0);
      check("gap_seen", {31'd0, (log_c[2] - log_c[1]) > 1}, 1);
      check("gap_last4", {31'd0, log_l[3]}, 1);
      check("gap_word4", {16'd0, log_d[3]}, 32'h0014);
    end

    // Downstream stalled for 10 cycles
    clear_log();
    m_ready = 1'b0;
    n0 = n_rd;
    push(16'hA5A5);
    push(16'h5A5A);
    push(16'h0F0F);
    k = 0;
    while (!m_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("stall_fill", {31'd0, m_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall10_valid", {31'd0, m_valid}, 1);
      check("stall10_data", {16'd0, m_data}, 32'hA5A5);
    end
    check("stall10_reads", {31'd0, (n_rd - n0) <= 2}, 1);
    push(16'h1234);
    m_ready = 1'b1;
    drain(100);
    check("stall_count", log_d.size(), 4);

`ifdef RD_STAGE_PARITY_EN
    clear_log();
    m_ready = 1'b0;
    push(16'h0007);
    push(16'h0003);
    push(16'h0000);
    push(16'h0000);
    k = 0;
    while (!m_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("par7_data", {16'd0, m_data}, 32'h0007);
    check("par7", {31'd0, m_parity}, 1);
    m_ready = 1'b1;
    tick(1);
    check("par3_data", {16'd0, m_data}, 32'h0003);
    check("par3", {31'd0, m_parity}, 0);
    drain(100);
`endif

    // Random ready over 200 words
    clear_log();
    for (int i = 0; i < 200; i++) push(W'($urandom));
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    check("rand_timeout", {31'd0, k < 3000}, 1);
    m_ready = 1'b1;
    drain(50);
    check("rand_count", log_d.size(), 200);

    // Reset during the second word of a burst
    clear_log();
    push(16'h0101);
    push(16'h0102);
    push(16'h0103);
    push(16'h0104);
    k = 0;
    while (!(m_valid && m_data == 16'h0102) && k < 30) begin
      tick(1);
      k++;
    end
    check("rst_mid_found", {16'd0, m_data}, 32'h0102);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_en", {31'd0, fifo_rd_en}, 0);
    check("arst_valid", {31'd0, m_valid}, 0);
    check("arst_data", {16'd0, m_data}, 0);
    check("arst_last", {31'd0, m_last}, 0);
    exp_q.delete();
    out_idx = 0;
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    rst_n = 1'b1;
    clear_log();
    push(16'h0201);
    push(16'h0202);
    push(16'h0203);
    push(16'h0204);
    drain(100);
    check("post_rst_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      check("post_rst_first", {16'd0, log_d[0]}, 32'h0201);
      check("post_rst_last0", {31'd0, log_l[0]}, 0);
      check("post_rst_last3", {31'd0, log_l[3]}, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
